json_vector_player: RTL and testbench
=====================================

Name: json_vector_player

Overview:
- Synthesizable, parametrised stimulus/response player; next generation of the DPI bench server.
- Vectors (stimulus, expected response, compare mask) are preloaded into an internal memory through a load port.
- On start: drives a DUT reset sequence, then applies one vector per cycle and checks the DUT response after a fixed latency.
- Reports done, pass, mismatch count and first failing index. Sits between the DUT and the bench top or a JTAG/CSR front end.

Parameters:
- IN_W, 34, packed DUT input width (e.g. {io_e, io_b, io_a}).
- OUT_W, 17, packed DUT output width (e.g. {io_v, io_z}).
- DEPTH, 256, vector memory entries; power of two, >= 2.
- LAT, 1, cycles from vector applied to response sampled; >= 1.
- RESET_CYCLES, 4, cycles dut_reset is held high before the first vector; >= 1.
- AW, $clog2(DEPTH), address width (derived).

Ports:
- clock  in  1  single clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  write one vector entry this cycle.
- load_addr  in  AW  entry index.
- load_stim  in  IN_W  stimulus for the entry.
- load_exp  in  OUT_W  expected response.
- load_mask  in  OUT_W  1 = compare bit, 0 = don't care.
- num_vectors  in  AW+1  vectors to run, 0..DEPTH; sampled at start.
- start  in  1  single-cycle pulse; accepted only in IDLE or DONE.
- dut_reset  out  1  active-high reset to the DUT.
- dut_in  out  IN_W  stimulus to the DUT.
- dut_out  in  OUT_W  response from the DUT.
- busy  out  1  high in RST, RUN or DRAIN.
- done  out  1  high in DONE until the next start.
- pass  out  1  valid while done; 1 iff mismatch_count == 0.
- mismatch_count  out  AW+1  number of failing vectors; saturates at all-ones.
- first_fail_idx  out  AW  index of the first failing vector; valid when mismatch_count != 0.

Behaviour:
- Reset values (reset_n low):
  - state = IDLE; dut_reset = 1; dut_in = 0; busy = 0; done = 0; pass = 0.
  - mismatch_count = 0; first_fail_idx = 0.
  - Compare pipeline valid bits cleared. Memory contents are not reset.
- Load port:
  - Write takes effect at posedge, one entry per cycle.
  - load_valid is ignored while busy (no write, no error).
- States and transitions:
  - IDLE/DONE: dut_reset = 1. On start, latch num_vectors, clear the counters and done, go to RST.
  - RST: dut_reset = 1 for exactly RESET_CYCLES cycles. Then go to RUN, or to DRAIN if num_vectors == 0.
  - RUN: dut_reset = 0. Cycle k drives dut_in = stim[k] for k = 0..num_vectors-1 (registered output, memory read one cycle ahead). After the last vector, go to DRAIN.
  - DRAIN: hold dut_in at the last stimulus for LAT cycles, then go to DONE. DONE remains until the next start.
  - start asserted while busy is ignored.
- Compare:
  - A LAT-deep shift register carries {valid, idx, exp, mask}, aligned with dut_in.
  - When its output is valid: mismatch iff ((dut_out ^ exp) & mask) != 0.
  - On the first mismatch, record first_fail_idx. Increment mismatch_count with saturation.
- Boundary conditions:
  - num_vectors > DEPTH is clamped to DEPTH.
  - num_vectors == 0 runs RST then DONE with pass = 1.
  - mask = 0 never fails.
  - Index wrap: the index counter is AW+1 bits, so DEPTH vectors terminate correctly.
  - reset_n low mid-run aborts immediately to reset values. The memory keeps its contents.
- Timing:
  - Total start-to-done = 1 + RESET_CYCLES + num_vectors + LAT cycles.
  - done asserts on the following edge.

Decomposition:
- Package json_vp_pkg holds:
  - state enum (IDLE, RST, RUN, DRAIN, DONE);
  - vector_entry_t struct {stim, exp, mask};
  - a saturating-increment function.
- Sub-module json_vp_mem: single write port / single registered read port RAM of vector_entry_t, DEPTH entries, no reset on the array.

Test Plan:
1. Load 4 vectors into a DUT model (z = a + b, v = e, LAT = 1); num_vectors = 4; pulse start -> dut_reset high 4 cycles; 4 vectors applied; done at cycle 10 after start; pass = 1; mismatch_count = 0.
2. Corrupt exp of vectors 1 and 3 -> mismatch_count = 2, first_fail_idx = 1, pass = 0.
3. Vector 2 has exp differing only in bit 0 and mask[0] = 0 -> pass = 1.
4. num_vectors = 0 -> done after RESET_CYCLES + LAT + 1 cycles, pass = 1, dut_reset never drops.
5. Assert reset_n low at vector 2 of 4; release; start again -> mid-run outputs return to reset values; the rerun passes using the same memory contents.
6. DEPTH = 4, num_vectors = 4 with all vectors failing, and start pulsed during RUN -> count = 4; the second start is ignored; the index wraps cleanly into DONE.

Source files
------------

// File: rtl/json_vp_pkg.sv
// Shared types for the vector player: FSM states, the default vector entry
// layout and a saturating counter helper.
package json_vp_pkg;

    localparam int VP_IN_W  = 34;
    localparam int VP_OUT_W = 17;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [VP_IN_W-1:0]  stim;
        logic [VP_OUT_W-1:0] exp;
        logic [VP_OUT_W-1:0] mask;
    } vector_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/json_vp_mem.sv
// Vector storage: one write port, one registered read port, DEPTH entries of
// whatever entry type the player hands in.
module json_vp_mem
    import json_vp_pkg::*;
#(
    parameter int  DEPTH   = 256,
    parameter type entry_t = vector_entry_t,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    entry_t mem [DEPTH];

    // NOTE: neither the array nor the read register is reset, so this maps onto
    // block RAM and the loaded vectors survive a reset_n pulse.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/json_vector_player.sv
// Stimulus/response player: holds the DUT in reset, replays one stored vector
// per cycle and scores the masked DUT response LAT cycles later.
module json_vector_player
    import json_vp_pkg::*;
#(
    parameter int  IN_W         = VP_IN_W,
    parameter int  OUT_W        = VP_OUT_W,
    parameter int  DEPTH        = 256,
    parameter int  LAT          = 1,
    parameter int  RESET_CYCLES = 4,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [AW-1:0]    load_addr,
    input  logic [IN_W-1:0]  load_stim,
    input  logic [OUT_W-1:0] load_exp,
    input  logic [OUT_W-1:0] load_mask,
    input  logic [AW:0]      num_vectors,
    input  logic             start,
    output logic             dut_reset,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [AW:0]      mismatch_count,
    output logic [AW-1:0]    first_fail_idx
);

    localparam int CW   = AW + 1;
    localparam int TMAX = (RESET_CYCLES > LAT) ? RESET_CYCLES : LAT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef struct packed {
        logic [IN_W-1:0]  stim;
        logic [OUT_W-1:0] exp;
        logic [OUT_W-1:0] mask;
    } entry_t;

    typedef struct packed {
        logic             valid;
        logic [AW-1:0]    idx;
        logic [OUT_W-1:0] exp;
        logic [OUT_W-1:0] mask;
    } cmp_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q;
    logic [CW-1:0]   nvec_q, idx_q, idx_next, nvec_clamped;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   ffi_q;
    logic [IN_W-1:0] dut_in_q;
    logic            dut_reset_q;
    cmp_t            pipe_q [LAT];
    entry_t          wr_entry, rd_entry;
    logic            start_ok, issue, rst_last, drain_last, mismatch;

    assign start_ok     = start && (state_q == IDLE || state_q == DONE);
    assign rst_last     = (timer_q == TW'(RESET_CYCLES - 1));
    assign drain_last   = (timer_q == TW'(LAT - 1));
    assign nvec_clamped = (num_vectors > CW'(DEPTH)) ? CW'(DEPTH) : num_vectors;

    // A vector is issued on every edge whose next state is RUN; the read address
    // runs one entry ahead so the registered RAM output is ready at the issue edge.
    assign issue    = (state_d == RUN);
    assign idx_next = issue ? idx_q + CW'(1) : idx_q;

    // NOTE: defaults are assigned before the case so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) state_d = RST;
            end
            RST: begin
                busy = 1'b1;
                if (rst_last) state_d = (nvec_q == '0) ? DRAIN : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (idx_q == nvec_q) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state updates are non-blocking so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (state_q == RST || state_q == DRAIN) begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

    assign wr_entry = '{stim: load_stim, exp: load_exp, mask: load_mask};

    json_vp_mem #(
        .DEPTH  (DEPTH),
        .entry_t(entry_t)
    ) u_mem (
        .clock(clock),
        .we   (load_valid && !busy),
        .waddr(load_addr),
        .wdata(wr_entry),
        .raddr(idx_next[AW-1:0]),
        .rdata(rd_entry)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= '{valid: issue, idx: idx_q[AW-1:0], exp: rd_entry.exp, mask: rd_entry.mask};
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign mismatch = |((dut_out ^ pipe_q[LAT-1].exp) & pipe_q[LAT-1].mask);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            nvec_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            ffi_q       <= '0;
            dut_in_q    <= '0;
            dut_reset_q <= 1'b1;
        end else begin
            if (pipe_q[LAT-1].valid && mismatch) begin
                if (cnt_q == '0) ffi_q <= pipe_q[LAT-1].idx;
                cnt_q <= CW'(sat_inc(32'(cnt_q), 32'({CW{1'b1}})));
            end
            if (issue) begin
                dut_in_q    <= rd_entry.stim;
                idx_q       <= idx_next;
                dut_reset_q <= 1'b0;
            end
            if (state_d == DONE && state_q == DRAIN) begin
                dut_reset_q <= 1'b1;
            end
            if (start_ok) begin
                nvec_q      <= nvec_clamped;
                idx_q       <= '0;
                cnt_q       <= '0;
                ffi_q       <= '0;
                dut_reset_q <= 1'b1;
            end
        end
    end

    assign dut_reset      = dut_reset_q;
    assign dut_in         = dut_in_q;
    assign pass           = done && (cnt_q == '0);
    assign mismatch_count = cnt_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_json_vector_player.sv
// Bench for json_vector_player with a small adder DUT model (z = a + b, v = e)
// on a DEPTH=4 instance so index wrap and the num_vectors clamp are reachable.
module tb_json_vector_player;

    localparam int IN_W   = 34;
    localparam int OUT_W  = 17;
    localparam int DEPTH  = 4;
    localparam int LAT    = 1;
    localparam int RC     = 4;
    localparam int AW     = 2;
    localparam int CW     = AW + 1;
    localparam int BUDGET = 64;

    logic             clock;
    logic             reset_n;
    logic             load_valid;
    logic [AW-1:0]    load_addr;
    logic [IN_W-1:0]  load_stim;
    logic [OUT_W-1:0] load_exp;
    logic [OUT_W-1:0] load_mask;
    logic [CW-1:0]    num_vectors;
    logic             start;
    logic             dut_reset;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CW-1:0]    mismatch_count;
    logic [AW-1:0]    first_fail_idx;

    int n_checks = 0;
    int n_pass   = 0;

    logic [IN_W-1:0]  m_stim [DEPTH];
    logic [OUT_W-1:0] m_exp  [DEPTH];
    logic [OUT_W-1:0] m_mask [DEPTH];

    typedef struct {
        int       n;
        bit [3:0] fail_set;
        bit [3:0] dc_set;
        bit       restart;
        bit       poke;
        int       e_cycles;
        bit       e_pass;
        int       e_cnt;
        int       e_first;
    } case_t;

    case_t cases [8];

    json_vector_player #(
        .IN_W        (IN_W),
        .OUT_W       (OUT_W),
        .DEPTH       (DEPTH),
        .LAT         (LAT),
        .RESET_CYCLES(RC)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .load_valid    (load_valid),
        .load_addr     (load_addr),
        .load_stim     (load_stim),
        .load_exp      (load_exp),
        .load_mask     (load_mask),
        .num_vectors   (num_vectors),
        .start         (start),
        .dut_reset     (dut_reset),
        .dut_in        (dut_in),
        .dut_out       (dut_out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .mismatch_count(mismatch_count),
        .first_fail_idx(first_fail_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // DUT model: a = in[15:0], b = in[31:16], e = in[33:32]; out = {e[0], a + b}.
    function automatic logic [OUT_W-1:0] golden(input logic [IN_W-1:0] s);
        logic [15:0] a;
        logic [15:0] b;
        a = s[15:0];
        b = s[31:16];
        return {s[32], a + b};
    endfunction

    assign dut_out = golden(dut_in);

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic load_all();
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clock);
            load_valid = 1'b1;
            load_addr  = AW'(k);
            load_stim  = m_stim[k];
            load_exp   = m_exp[k];
            load_mask  = m_mask[k];
        end
        @(negedge clock);
        load_valid = 1'b0;
    endtask

    // Expected results straight from the scoring rule: count masked differences
    // over the first min(n, DEPTH) vectors.
    function automatic void predict(input int n, output int cyc, output bit ok,
                                    output int cnt, output int first);
        int n_eff;
        n_eff = (n > DEPTH) ? DEPTH : n;
        cnt   = 0;
        first = 0;
        for (int k = 0; k < n_eff; k++) begin
            if (((golden(m_stim[k]) ^ m_exp[k]) & m_mask[k]) != '0) begin
                if (cnt == 0) first = k;
                cnt++;
            end
        end
        ok  = (cnt == 0);
        cyc = 1 + RC + n_eff + LAT;
    endfunction

    // Pulses start, follows the run cycle by cycle against the expected
    // RST/RUN/DRAIN waveform, then scores the final report.
    task automatic run_and_check(input string tag, input int n, input bit restart, input bit poke,
                                 input int e_cycles, input bit e_pass, input int e_cnt, input int e_first);
        int n_eff;
        int bad;
        int j;
        n_eff = (n > DEPTH) ? DEPTH : n;
        bad   = 0;
        @(negedge clock);
        num_vectors = CW'(n);
        start       = 1'b1;
        @(negedge clock);
        start       = 1'b0;
        num_vectors = '1;
        j = 0;
        while (!done && j < BUDGET) begin
            if (j < RC) begin
                if (!(dut_reset && busy)) bad++;
            end else if (j < RC + n_eff) begin
                if (dut_reset || !busy || dut_in !== m_stim[j-RC]) bad++;
            end else if (j < RC + n_eff + LAT) begin
                if (!busy || dut_reset !== (n_eff == 0)) bad++;
                else if (n_eff != 0 && dut_in !== m_stim[n_eff-1]) bad++;
            end else begin
                bad++;
            end
            load_valid = poke && (j == 1);
            if (poke && j == 1) begin
                load_addr = '0;
                load_stim = ~m_stim[0];
                load_exp  = '0;
                load_mask = '1;
            end
            start = restart && (j == RC + 1);
            @(negedge clock);
            j++;
        end
        load_valid = 1'b0;
        start      = 1'b0;
        check({tag, ".done_seen"}, done, 1);
        check({tag, ".trace_errors"}, bad, 0);
        check({tag, ".cycles"}, j + 1, e_cycles);
        check({tag, ".pass"}, pass, e_pass);
        check({tag, ".mismatch_count"}, mismatch_count, e_cnt);
        if (e_cnt != 0) check({tag, ".first_fail_idx"}, first_fail_idx, e_first);
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        load_valid  = 1'b0;
        load_addr   = '0;
        load_stim   = '0;
        load_exp    = '0;
        load_mask   = '0;
        num_vectors = '0;

        //           n  fail     dc       rs poke cyc pass cnt first
        cases[0] = '{4, 4'b0000, 4'b0000, 0, 0,   10, 1,   0,  0};
        cases[1] = '{4, 4'b1010, 4'b0000, 0, 0,   10, 0,   2,  1};
        cases[2] = '{4, 4'b0000, 4'b0100, 0, 0,   10, 1,   0,  0};
        cases[3] = '{0, 4'b0000, 4'b0000, 0, 0,   6,  1,   0,  0};
        cases[4] = '{4, 4'b1111, 4'b0000, 1, 0,   10, 0,   4,  0};
        cases[5] = '{7, 4'b0100, 4'b0000, 0, 0,   10, 0,   1,  2};
        cases[6] = '{2, 4'b1000, 4'b0000, 0, 1,   8,  1,   0,  0};
        cases[7] = '{3, 4'b0100, 4'b0000, 0, 0,   9,  0,   1,  2};

        repeat (3) @(negedge clock);
        check("reset.dut_reset", dut_reset, 1);
        check("reset.dut_in", dut_in, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.pass", pass, 0);
        check("reset.mismatch_count", mismatch_count, 0);
        check("reset.first_fail_idx", first_fail_idx, 0);
        reset_n = 1'b1;

        for (int k = 0; k < DEPTH; k++) m_stim[k] = IN_W'({$urandom(), $urandom()});

        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_exp[k]  = golden(m_stim[k]) ^ (cases[c].fail_set[k] ? OUT_W'(32) : '0)
                                              ^ (cases[c].dc_set[k]   ? OUT_W'(1)  : '0);
                m_mask[k] = cases[c].dc_set[k] ? ~OUT_W'(1) : '1;
            end
            load_all();
            run_and_check($sformatf("case%0d", c), cases[c].n, cases[c].restart, cases[c].poke,
                          cases[c].e_cycles, cases[c].e_pass, cases[c].e_cnt, cases[c].e_first);
        end

        // Abort while vector 2 of 4 is on dut_in, then rerun from the same memory.
        for (int k = 0; k < DEPTH; k++) begin
            m_exp[k]  = golden(m_stim[k]);
            m_mask[k] = '1;
        end
        load_all();
        @(negedge clock);
        num_vectors = CW'(4);
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (RC + 2) @(negedge clock);
        check("midrst.dut_in_before", dut_in, m_stim[2]);
        check("midrst.busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check("midrst.dut_reset", dut_reset, 1);
        check("midrst.dut_in", dut_in, 0);
        check("midrst.busy", busy, 0);
        check("midrst.done", done, 0);
        check("midrst.pass", pass, 0);
        check("midrst.mismatch_count", mismatch_count, 0);
        @(negedge clock);
        reset_n = 1'b1;
        run_and_check("midrst.rerun", 4, 1'b0, 1'b0, 10, 1'b1, 0, 0);

        for (int r = 0; r < 20; r++) begin
            int n;
            int cyc;
            int cnt;
            int first;
            bit ok;
            for (int k = 0; k < DEPTH; k++) begin
                int mode;
                mode      = $urandom_range(0, 3);
                m_stim[k] = IN_W'({$urandom(), $urandom()});
                if (mode == 0) m_exp[k] = OUT_W'($urandom());
                else if (mode == 1) m_exp[k] = golden(m_stim[k]) ^ OUT_W'(1 << $urandom_range(0, 16));
                else m_exp[k] = golden(m_stim[k]);
                m_mask[k] = ($urandom_range(0, 4) == 0) ? '0 : OUT_W'($urandom());
            end
            load_all();
            n = $urandom_range(0, 7);
            predict(n, cyc, ok, cnt, first);
            run_and_check($sformatf("rand%0d", r), n, 1'b0, 1'b0, cyc, ok, cnt, first);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
